// File: rtl/pzcorebus_pkg.sv
// Shared pzcorebus types and width helpers. Derived widths are clamped to at
// least one bit so an unconfigured ('0) bus still elaborates.
package pzcorebus_pkg;

  typedef enum logic [1:0] {
    PZCOREBUS_CSR      = 2'b00,
    PZCOREBUS_MEMORY_H = 2'b01,
    PZCOREBUS_MEMORY_L = 2'b10
  } pzcorebus_profile;

  typedef struct packed {
    pzcorebus_profile profile;
    int               address_width;
    int               data_width;
    int               unit_data_width;
    int               max_data_width;
    int               max_length;
    int               id_width;
  } pzcorebus_config;

  // Bit 3 set marks a non-posted command.
  typedef enum logic [3:0] {
    PZCOREBUS_NULL_COMMAND          = 4'b0000,
    PZCOREBUS_WRITE                 = 4'b0001,
    PZCOREBUS_BROADCAST             = 4'b0010,
    PZCOREBUS_FULL_WRITE            = 4'b0011,
    PZCOREBUS_ATOMIC                = 4'b0100,
    PZCOREBUS_READ                  = 4'b1000,
    PZCOREBUS_WRITE_NON_POSTED      = 4'b1001,
    PZCOREBUS_BROADCAST_NON_POSTED  = 4'b1010,
    PZCOREBUS_FULL_WRITE_NON_POSTED = 4'b1011,
    PZCOREBUS_ATOMIC_NON_POSTED     = 4'b1100
  } pzcorebus_command_type;

  typedef enum logic [1:0] {
    PZCOREBUS_NULL_RESPONSE      = 2'b00,
    PZCOREBUS_RESPONSE           = 2'b10,
    PZCOREBUS_RESPONSE_WITH_DATA = 2'b11
  } pzcorebus_response_type;

  localparam int PZCOREBUS_MAX_ID_WIDTH     = 32;
  localparam int PZCOREBUS_MAX_OFFSET_WIDTH = 16;
  localparam int PZCOREBUS_MAX_SIZE_WIDTH   = 16;
  localparam int PZCOREBUS_MAX_UNITEN_WIDTH = 64;

  typedef struct packed {
    pzcorebus_response_type                sresp;
    logic [PZCOREBUS_MAX_ID_WIDTH-1:0]     sid;
    logic [PZCOREBUS_MAX_OFFSET_WIDTH-1:0] offset;
    logic [PZCOREBUS_MAX_SIZE_WIDTH-1:0]   size;
    logic [PZCOREBUS_MAX_UNITEN_WIDTH-1:0] uniten;
    logic [1:0]                            last;
  } pzcorebus_response_beat;

  function automatic int pzcorebus_max1(int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int pzcorebus_clog2_min1(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int pzcorebus_get_data_size(pzcorebus_config cfg);
    return (cfg.unit_data_width <= 0) ? 1 : pzcorebus_max1(cfg.data_width / cfg.unit_data_width);
  endfunction

  function automatic int pzcorebus_get_max_data_size(pzcorebus_config cfg);
    return (cfg.unit_data_width <= 0) ? 1 : pzcorebus_max1(cfg.max_data_width / cfg.unit_data_width);
  endfunction

  function automatic int pzcorebus_get_unit_byte_lsb(pzcorebus_config cfg);
    return (cfg.unit_data_width >= 8) ? $clog2(cfg.unit_data_width) - 3 : 0;
  endfunction

  function automatic int pzcorebus_get_address_width(pzcorebus_config cfg);
    return pzcorebus_max1(cfg.address_width);
  endfunction

  function automatic int pzcorebus_get_id_width(pzcorebus_config cfg);
    return pzcorebus_max1(cfg.id_width);
  endfunction

  function automatic int pzcorebus_get_max_length(pzcorebus_config cfg);
    return pzcorebus_max1(cfg.max_length);
  endfunction

  // Packed length: 0 encodes max_length.
  function automatic int pzcorebus_get_length_width(pzcorebus_config cfg);
    return pzcorebus_clog2_min1(pzcorebus_get_max_length(cfg));
  endfunction

  function automatic int pzcorebus_get_unpacked_length_width(pzcorebus_config cfg);
    return $clog2(pzcorebus_get_max_length(cfg) + 1);
  endfunction

  function automatic int pzcorebus_get_response_offset_width(pzcorebus_config cfg);
    return pzcorebus_clog2_min1(pzcorebus_get_max_data_size(cfg));
  endfunction

  function automatic int pzcorebus_get_response_size_width(pzcorebus_config cfg);
    return $clog2(pzcorebus_get_data_size(cfg) + 1);
  endfunction

  function automatic int pzcorebus_get_unit_enable_width(pzcorebus_config cfg);
    return pzcorebus_get_data_size(cfg);
  endfunction

  function automatic logic pzcorebus_is_non_posted(pzcorebus_command_type cmd);
    return cmd[3];
  endfunction

  function automatic logic pzcorebus_is_read(pzcorebus_command_type cmd);
    return cmd == PZCOREBUS_READ;
  endfunction

  function automatic logic pzcorebus_has_response_data(pzcorebus_command_type cmd);
    return (cmd == PZCOREBUS_READ) || (cmd == PZCOREBUS_ATOMIC_NON_POSTED);
  endfunction

endpackage

// File: rtl/pzbcm_fifo.sv
// Small synchronous FIFO; full/empty come straight from the registered count,
// so a push on a full queue is refused even when a pop happens the same cycle.
module pzbcm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;

  assign o_empty = count == '0;
  assign o_full  = count == CW'(DEPTH);
  assign push    = i_push && !o_full;
  assign pop     = i_pop && !o_empty;
  assign o_data  = mem[rd_ptr];

  function automatic logic [PW-1:0] inc(logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end
endmodule

// File: rtl/pzcorebus_response_sequencer.sv
// Queues non-posted commands and walks each one into response beat
// descriptors, one per cycle, under valid/ready backpressure.
module pzcorebus_response_sequencer
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG    = '0,
  parameter int              COMMAND_DEPTH = 2,
  localparam int AW        = pzcorebus_get_address_width(BUS_CONFIG),
  localparam int IW        = pzcorebus_get_id_width(BUS_CONFIG),
  localparam int LW        = pzcorebus_get_length_width(BUS_CONFIG),
  localparam int OW        = pzcorebus_get_response_offset_width(BUS_CONFIG),
  localparam int SW        = pzcorebus_get_response_size_width(BUS_CONFIG),
  localparam int DATA_SIZE = pzcorebus_get_unit_enable_width(BUS_CONFIG)
)(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_command_valid,
  output logic                   o_command_ready,
  input  pzcorebus_command_type  i_mcmd,
  input  logic [AW-1:0]          i_maddr,
  input  logic [LW-1:0]          i_mlength,
  input  logic [IW-1:0]          i_mid,
  output logic                   o_beat_valid,
  input  logic                   i_beat_ready,
  output pzcorebus_response_type o_sresp,
  output logic [IW-1:0]          o_sid,
  output logic [OW-1:0]          o_offset,
  output logic [SW-1:0]          o_size,
  output logic [DATA_SIZE-1:0]   o_uniten,
  output logic [1:0]             o_last,
  output logic                   o_busy
);
  localparam int  MAX_DATA_SIZE = pzcorebus_get_max_data_size(BUS_CONFIG);
  localparam int  MAX_LENGTH    = pzcorebus_get_max_length(BUS_CONFIG);
  localparam int  ULW           = pzcorebus_get_unpacked_length_width(BUS_CONFIG);
  localparam int  RW            = (ULW > SW) ? ULW : SW;
  localparam int  UNIT_LSB      = pzcorebus_get_unit_byte_lsb(BUS_CONFIG);
  localparam bit  MEM_H         = BUS_CONFIG.profile == PZCOREBUS_MEMORY_H;
  // Non-read commands answer with one full-width beat (memory-H) or one unit.
  localparam int  NONREAD_LEN   = MEM_H ? DATA_SIZE : 1;

  typedef struct packed {
    pzcorebus_command_type mcmd;
    logic [OW-1:0]         offset;
    logic [RW-1:0]         length;
    logic [IW-1:0]         id;
  } command_entry;

  typedef enum logic {IDLE, BURST} state_e;

  state_e                 state, state_next;
  command_entry           push_entry, head;
  logic                   q_empty, q_full, push, load, beat_ack, last0;
  pzcorebus_command_type  cur_cmd;
  logic [IW-1:0]          cur_id;
  logic [OW-1:0]          offset;
  logic [RW-1:0]          remaining;
  int                     lo, size;
  pzcorebus_response_beat beat;
  logic                   unused_beat;

  function automatic logic [OW-1:0] initial_offset(logic [AW-1:0] addr);
    logic [AW-1:0] shifted;
    shifted = addr >> UNIT_LSB;
    return (MEM_H && MAX_DATA_SIZE > 1) ? OW'(shifted) : '0;
  endfunction

  function automatic logic [RW-1:0] unpack_length(logic [LW-1:0] len);
    return (len == '0) ? RW'(MAX_LENGTH) : RW'(len);
  endfunction

  function automatic int beat_lo(logic [OW-1:0] off);
    return MEM_H ? int'(off) % DATA_SIZE : 0;
  endfunction

  function automatic int beat_size(int beat_lo_units, logic [RW-1:0] rem);
    if (!MEM_H) return 1;
    return (DATA_SIZE - beat_lo_units < int'(rem)) ? DATA_SIZE - beat_lo_units : int'(rem);
  endfunction

  function automatic logic [DATA_SIZE-1:0] beat_uniten(int beat_lo_units, int beat_units);
    logic [DATA_SIZE-1:0] u;
    for (int i = 0; i < DATA_SIZE; i++)
      u[i] = MEM_H && (i >= beat_lo_units) && (i < beat_lo_units + beat_units);
    return u;
  endfunction

  // Next beat starts at the following data_width boundary, wrapping in max_data_width.
  function automatic logic [OW-1:0] next_offset(logic [OW-1:0] off);
    return MEM_H ? OW'((((int'(off) / DATA_SIZE) + 1) * DATA_SIZE) % MAX_DATA_SIZE) : '0;
  endfunction

  assign o_command_ready = !q_full && !i_rst;
  assign push            = i_command_valid && o_command_ready && pzcorebus_is_non_posted(i_mcmd);
  assign push_entry      = '{mcmd: i_mcmd, offset: initial_offset(i_maddr),
                             length: unpack_length(i_mlength), id: i_mid};

  pzbcm_fifo #(
    .WIDTH ($bits(command_entry)),
    .DEPTH (COMMAND_DEPTH)
  ) u_command_queue (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (push_entry),
    .i_pop   (load),
    .o_data  (head),
    .o_empty (q_empty),
    .o_full  (q_full)
  );

  always_comb begin
    lo    = beat_lo(offset);
    size  = beat_size(lo, remaining);
    last0 = int'(remaining) == size;
    beat  = '0;
    if (state == BURST) begin
      beat.sresp  = pzcorebus_has_response_data(cur_cmd) ? PZCOREBUS_RESPONSE_WITH_DATA
                                                         : PZCOREBUS_RESPONSE;
      beat.sid    = PZCOREBUS_MAX_ID_WIDTH'(cur_id);
      beat.offset = PZCOREBUS_MAX_OFFSET_WIDTH'(offset);
      beat.size   = PZCOREBUS_MAX_SIZE_WIDTH'(size);
      beat.uniten = PZCOREBUS_MAX_UNITEN_WIDTH'(beat_uniten(lo, size));
      beat.last   = {last0 || (int'(offset) + size == MAX_DATA_SIZE), last0};
    end
  end

  assign o_beat_valid = state == BURST;
  assign o_sresp      = beat.sresp;
  assign o_sid        = beat.sid[IW-1:0];
  assign o_offset     = beat.offset[OW-1:0];
  assign o_size       = beat.size[SW-1:0];
  assign o_uniten     = beat.uniten[DATA_SIZE-1:0];
  assign o_last       = beat.last;
  assign o_busy       = (state == BURST) || !q_empty;
  assign unused_beat  = ^beat;
  assign beat_ack     = (state == BURST) && i_beat_ready;

  // Loading the next head shares the edge with the final handshake, so a
  // queued command follows without a bubble.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: if (!q_empty) begin
        load       = 1'b1;
        state_next = BURST;
      end
      BURST: if (beat_ack && last0) begin
        if (!q_empty) load = 1'b1;
        else          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cur_cmd   <= PZCOREBUS_NULL_COMMAND;
      cur_id    <= '0;
      offset    <= '0;
      remaining <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        cur_cmd   <= head.mcmd;
        cur_id    <= head.id;
        offset    <= head.offset;
        remaining <= pzcorebus_is_read(head.mcmd) ? head.length : RW'(NONREAD_LEN);
      end else if (beat_ack) begin
        offset    <= next_offset(offset);
        remaining <= remaining - RW'(size);
      end
    end
  end
endmodule

// File: tb/tb_pzcorebus_response_sequencer.sv
// Directed bench: 256-bit data, 32-bit units, 512-bit max data, memory-H.
module tb_pzcorebus_response_sequencer;
  import pzcorebus_pkg::*;

  localparam pzcorebus_config CFG = '{
    profile: PZCOREBUS_MEMORY_H, address_width: 32, data_width: 256,
    unit_data_width: 32, max_data_width: 512, max_length: 256, id_width: 4
  };
  localparam logic [1:0] RSP = 2'b10;
  localparam logic [1:0] RWD = 2'b11;

  logic                   i_clk, i_rst, i_command_valid, o_command_ready;
  pzcorebus_command_type  i_mcmd;
  logic [31:0]            i_maddr;
  logic [7:0]             i_mlength;
  logic [3:0]             i_mid;
  logic                   o_beat_valid, i_beat_ready, o_busy;
  pzcorebus_response_type o_sresp;
  logic [3:0]             o_sid, o_offset, o_size;
  logic [7:0]             o_uniten;
  logic [1:0]             o_last;

  int checks   = 0;
  int failures = 0;

  pzcorebus_response_sequencer #(
    .BUS_CONFIG    (CFG),
    .COMMAND_DEPTH (2)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_command_valid (i_command_valid),
    .o_command_ready (o_command_ready),
    .i_mcmd          (i_mcmd),
    .i_maddr         (i_maddr),
    .i_mlength       (i_mlength),
    .i_mid           (i_mid),
    .o_beat_valid    (o_beat_valid),
    .i_beat_ready    (i_beat_ready),
    .o_sresp         (o_sresp),
    .o_sid           (o_sid),
    .o_offset        (o_offset),
    .o_size          (o_size),
    .o_uniten        (o_uniten),
    .o_last          (o_last),
    .o_busy          (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [23:0] bvec(logic [1:0] sresp, logic [3:0] id, logic [3:0] off,
                                       logic [3:0] sz, logic [7:0] uen, logic [1:0] last);
    return {sresp, id, off, sz, uen, last};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {o_sresp, o_sid, o_offset, o_size, o_uniten, o_last};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds the command until accepted; returns at the negedge after the handshake.
  task automatic send(input string tag, input pzcorebus_command_type cmd,
                      input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    i_command_valid = 1'b1;
    i_mcmd = cmd; i_maddr = addr; i_mlength = len; i_mid = id;
    for (int n = 0; n < 40 && !o_command_ready; n++) @(negedge i_clk);
    chk({tag, "_accept"}, o_command_ready, 1);
    @(negedge i_clk);
    i_command_valid = 1'b0;
  endtask

  // Waits for a beat, compares it, then takes it with a one-cycle ready.
  task automatic expect_beat(input string tag, input logic [23:0] exp);
    for (int n = 0; n < 20 && !o_beat_valid; n++) @(negedge i_clk);
    chk({tag, "_vld"}, o_beat_valid, 1);
    chk(tag, obs_vec(), exp);
    i_beat_ready = 1'b1;
    @(negedge i_clk);
    i_beat_ready = 1'b0;
  endtask

  task automatic expect_quiet(input string tag);
    chk({tag, "_vld"}, o_beat_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_command_valid = 1'b0; i_beat_ready = 1'b0;
    i_mcmd = PZCOREBUS_NULL_COMMAND; i_maddr = '0; i_mlength = '0; i_mid = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_ready", o_command_ready, 0);
    chk("rst_vld", o_beat_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_desc", obs_vec(), 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_rst_ready", o_command_ready, 1);

    // Unaligned read crossing one data_width boundary, plus N+2 latency.
    send("t1", PZCOREBUS_READ, 32'h14, 8'd10, 4'd1);
    chk("t1_lat_n1_vld", o_beat_valid, 0);
    chk("t1_lat_n1_busy", o_busy, 1);
    @(negedge i_clk);
    chk("t1_lat_n2_vld", o_beat_valid, 1);
    expect_beat("t1_b1", bvec(RWD, 4'd1, 4'd5, 4'd3, 8'hE0, 2'b00));
    expect_beat("t1_b2", bvec(RWD, 4'd1, 4'd8, 4'd7, 8'h7F, 2'b11));
    expect_quiet("t1_end");

    // Max-length read: 32 full beats alternating across the 512-bit chunk.
    send("t2", PZCOREBUS_READ, 32'h0, 8'd0, 4'd2);
    for (int k = 0; k < 32; k++)
      expect_beat($sformatf("t2_b%0d", k),
                  bvec(RWD, 4'd2, (k % 2 == 1) ? 4'd8 : 4'd0, 4'd8, 8'hFF,
                       {(k % 2 == 1), (k == 31)}));
    expect_quiet("t2_end");

    // Non-posted write, posted write (no beat), then read; no bubble between.
    send("t3_wnp", PZCOREBUS_WRITE_NON_POSTED, 32'h40, 8'd4, 4'd3);
    send("t3_wp", PZCOREBUS_WRITE, 32'h80, 8'd4, 4'd4);
    send("t3_rd", PZCOREBUS_READ, 32'h0, 8'd8, 4'd5);
    expect_beat("t3_wnp", bvec(RSP, 4'd3, 4'd0, 4'd8, 8'hFF, 2'b11));
    chk("t3_no_bubble", o_beat_valid, 1);
    expect_beat("t3_rd", bvec(RWD, 4'd5, 4'd0, 4'd8, 8'hFF, 2'b11));
    for (int k = 0; k < 3; k++) begin
      expect_quiet($sformatf("t3_extra%0d", k));
      @(negedge i_clk);
    end

    // Stall the second beat for three cycles.
    send("t4", PZCOREBUS_READ, 32'h8, 8'd20, 4'd6);
    expect_beat("t4_b1", bvec(RWD, 4'd6, 4'd2, 4'd6, 8'hFC, 2'b00));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_stall%0d_vld", k), o_beat_valid, 1);
      chk($sformatf("t4_stall%0d", k), obs_vec(), bvec(RWD, 4'd6, 4'd8, 4'd8, 8'hFF, 2'b10));
      @(negedge i_clk);
    end
    expect_beat("t4_b2", bvec(RWD, 4'd6, 4'd8, 4'd8, 8'hFF, 2'b10));
    expect_beat("t4_b3", bvec(RWD, 4'd6, 4'd0, 4'd6, 8'h3F, 2'b11));
    expect_quiet("t4_end");

    // Fill the two-entry queue behind a stalled beat; fourth push waits.
    send("t5_c0", PZCOREBUS_READ, 32'h0, 8'd8, 4'd8);
    send("t5_c1", PZCOREBUS_READ, 32'h0, 8'd8, 4'd9);
    send("t5_c2", PZCOREBUS_READ, 32'h0, 8'd8, 4'd10);
    chk("t5_full_ready", o_command_ready, 0);
    i_command_valid = 1'b1; i_mcmd = PZCOREBUS_READ; i_maddr = 32'h0; i_mlength = 8'd8; i_mid = 4'd11;
    @(negedge i_clk);
    chk("t5_full_ready_hold", o_command_ready, 0);
    expect_beat("t5_c0", bvec(RWD, 4'd8, 4'd0, 4'd8, 8'hFF, 2'b11));
    chk("t5_ready_after_pop", o_command_ready, 1);
    @(negedge i_clk);
    i_command_valid = 1'b0;
    expect_beat("t5_c1", bvec(RWD, 4'd9, 4'd0, 4'd8, 8'hFF, 2'b11));
    expect_beat("t5_c2", bvec(RWD, 4'd10, 4'd0, 4'd8, 8'hFF, 2'b11));
    expect_beat("t5_c3", bvec(RWD, 4'd11, 4'd0, 4'd8, 8'hFF, 2'b11));
    for (int k = 0; k < 3; k++) begin
      expect_quiet($sformatf("t5_extra%0d", k));
      @(negedge i_clk);
    end

    // Reset during beat 2 of 4 with another command still queued.
    send("t6_rd", PZCOREBUS_READ, 32'h0, 8'd32, 4'd12);
    send("t6_wnp", PZCOREBUS_WRITE_NON_POSTED, 32'h0, 8'd1, 4'd13);
    expect_beat("t6_b1", bvec(RWD, 4'd12, 4'd0, 4'd8, 8'hFF, 2'b00));
    chk("t6_b2_presented", o_beat_valid, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    expect_quiet("t6_in_rst");
    chk("t6_in_rst_ready", o_command_ready, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    expect_quiet("t6_after_rst");
    chk("t6_after_rst_ready", o_command_ready, 1);
    send("t6_new", PZCOREBUS_READ, 32'h14, 8'd10, 4'd14);
    expect_beat("t6_new_b1", bvec(RWD, 4'd14, 4'd5, 4'd3, 8'hE0, 2'b00));
    expect_beat("t6_new_b2", bvec(RWD, 4'd14, 4'd8, 4'd7, 8'h7F, 2'b11));
    expect_quiet("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
